m_cnt_gen: RTL and testbench
============================

// Module: m_cnt_gen
// PURPOSE
//  Parametrised up/down modulo counter with prescaler, synchronous load, wrap or
//  saturate mode and a one-cycle terminal-count pulse. Successor to the fixed 2-bit
//  free-running counter; used for timebases, tick generation and LED/display scanning.
// PARAMETERS
//  WIDTH    4    counter width in bits (1..32)
//  MODULUS  10   count range 0..MODULUS-1 (2..2**WIDTH)
//  PRE_W    8    prescaler width in bits; prescaler reload value comes from w_pre
// PORTS
//  w_clk    in   1        clock, rising edge
//  w_rst_n  in   1        asynchronous reset, active low
//  w_en     in   1        count enable
//  w_dir    in   1        1 = up, 0 = down
//  w_sat    in   1        1 = saturate at the range ends, 0 = wrap
//  w_ld     in   1        synchronous load strobe
//  w_ld_val in   WIDTH    load value
//  w_pre    in   PRE_W    prescale divisor minus 1 (0 = step every enabled cycle)
//  w_cnt    out  WIDTH    current count (registered)
//  w_tc     out  1        terminal-count pulse, registered, 1 cycle wide
//  w_tick   out  1        prescaler tick (combinational from prescaler state and w_en)
// BEHAVIOUR
//  Clock and reset
//   - One clock domain. w_clk is the only clock.
//   - Reset is asynchronous and active low.
//   - While w_rst_n=0: w_cnt=0, w_tc=0, prescaler=0, w_tick=0.
//   - Release is sampled on the first rising edge with w_rst_n=1.
//   - Reset asserted mid-count clears all state immediately, without waiting for an edge.
//  Prescaler
//   - Counts 0..w_pre while w_en=1 and holds while w_en=0.
//   - w_tick=1 when prescaler==w_pre and w_en=1.
//   - The prescaler returns to 0 on the edge where w_tick=1.
//   - If w_pre changes below the current prescaler value, the next tick occurs after
//     wrap-through; no lock-up is permitted.
//  Priority per rising edge: load > step > hold
//   - Load: if w_ld=1, w_cnt <= w_ld_val, or MODULUS-1 when w_ld_val >= MODULUS.
//     Load also resets the prescaler to 0 and suppresses w_tc.
//     Load is honoured even when w_en=0.
//   - Step: if w_tick=1, w_cnt moves by one in the direction given by w_dir.
//   - Hold: otherwise w_cnt is unchanged.
//  Range ends and terminal count
//   - The range ends are MODULUS-1 when counting up and 0 when counting down.
//   - Wrap mode (w_sat=0), up: MODULUS-1 -> 0.
//   - Wrap mode (w_sat=0), down: 0 -> MODULUS-1.
//   - Saturate mode (w_sat=1): the count sticks at the range end.
//   - Terminal count: a step taken while w_cnt is at the range end for the current w_dir.
//     w_tc=1 on the following cycle in both wrap and saturate mode.
//     In saturate mode w_tc repeats on every such tick.
//   - The terminal-count condition is evaluated on the pre-step value, so w_dir toggling
//     on the same edge uses the new w_dir.
//  Latency and width rules
//   - w_cnt changes one edge after the tick or load cycle.
//   - w_tc is aligned with the cycle in which w_cnt shows the wrapped/saturated value.
//   - All arithmetic is unsigned WIDTH-bit; the compare against MODULUS-1 is exact,
//     so out-of-range states are unreachable.
//   - w_cnt never exceeds MODULUS-1, including when MODULUS=2**WIDTH.
// TESTING
//  1 Reset: assert w_rst_n=0 between clock edges -> w_cnt=0 and w_tc=0 immediately,
//    not at the next edge.
//  2 Up-wrap (WIDTH=4, MODULUS=10, w_pre=0, w_en=1, w_dir=1) -> w_cnt runs 0..9,0;
//    w_tc=1 exactly in the cycle showing 0 after 9.
//  3 Prescale (w_pre=3) -> w_tick every 4th cycle; w_cnt advances once per 4 cycles;
//    dropping w_en for 2 cycles delays the next tick by 2 cycles.
//  4 Down-saturate (w_dir=0, w_sat=1, load 2) -> 2,1,0,0,0;
//    w_tc pulses on each tick taken at 0.
//  5 Load precedence: w_ld=1 with w_ld_val=7 on a tick cycle -> w_cnt=7, no w_tc;
//    w_ld_val=12 -> w_cnt=9.
//  6 Full range (WIDTH=3, MODULUS=8, up, wrap) -> 7->0 wrap with w_tc;
//    a mid-run async reset returns w_cnt to 0 and the count resumes 0,1,... after release.

Source files
------------

// File: rtl/m_cnt_gen.sv
// m_cnt_gen: parametrised up/down modulo counter with prescaler, synchronous
// load, wrap or saturate mode and a one-cycle terminal-count pulse.
`timescale 1ns/1ps

module m_cnt_gen #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 10,
   parameter int unsigned     PRE_W   = 8
) (
   input  logic             w_clk,
   input  logic             w_rst_n,
   input  logic             w_en,
   input  logic             w_dir,
   input  logic             w_sat,
   input  logic             w_ld,
   input  logic [WIDTH-1:0] w_ld_val,
   input  logic [PRE_W-1:0] w_pre,
   output logic [WIDTH-1:0] w_cnt,
   output logic             w_tc,
   output logic             w_tick
);

   // Highest count value; MODULUS may equal 2**WIDTH, so subtract before truncating.
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 64'd1);

   // Elaboration-time guard on the parameter ranges.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("m_cnt_gen: WIDTH must be 1..32");
   end
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("m_cnt_gen: MODULUS must be 2..2**WIDTH");
   end
   if (PRE_W < 1) begin : g_bad_pre_w
      $error("m_cnt_gen: PRE_W must be at least 1");
   end

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic [WIDTH-1:0] cnt_d;
   logic             tc_d;
   logic             at_end;
   logic [WIDTH-1:0] ld_clamp;

   // Prescaler tick; gated by reset so it reads 0 while the block is held in reset.
   assign w_tick = w_rst_n & w_en & (pre_q == w_pre);

   // Range end for the current direction: top when counting up, zero when counting down.
   assign at_end = w_dir ? (w_cnt == CNT_MAX) : (w_cnt == '0);

   // Out-of-range load values are clamped to the top of the range.
   assign ld_clamp = (64'(w_ld_val) >= MODULUS) ? CNT_MAX : w_ld_val;

   // Next-state logic: load beats step beats hold.
   always_comb begin
      pre_d = pre_q;
      cnt_d = w_cnt;
      tc_d  = 1'b0;

      if (w_ld) begin
         cnt_d = ld_clamp;
         pre_d = '0;
      end else if (w_tick) begin
         pre_d = '0;
         tc_d  = at_end;
         if (at_end) begin
            if (!w_sat) begin
               cnt_d = w_dir ? '0 : CNT_MAX;
            end
         end else if (w_dir) begin
            cnt_d = w_cnt + WIDTH'(1);
         end else begin
            cnt_d = w_cnt - WIDTH'(1);
         end
      end else if (w_en) begin
         // Free-running increment also covers w_pre dropping below the current value.
         pre_d = pre_q + PRE_W'(1);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         pre_q <= '0;
         w_cnt <= '0;
         w_tc  <= 1'b0;
      end else begin
         pre_q <= pre_d;
         w_cnt <= cnt_d;
         w_tc  <= tc_d;
      end
   end

endmodule

// File: tb/tb_m_cnt_gen.sv
// Directed self-checking bench for m_cnt_gen (10-state and full-range 8-state instances).
`timescale 1ns/1ps

module tb_m_cnt_gen;

   logic       clk;
   // Instance A: WIDTH=4, MODULUS=10, PRE_W=8
   logic       a_rst_n, a_en, a_dir, a_sat, a_ld;
   logic [3:0] a_ld_val;
   logic [7:0] a_pre;
   logic [3:0] a_cnt;
   logic       a_tc, a_tick;
   // Instance B: WIDTH=3, MODULUS=8, PRE_W=4
   logic       b_rst_n, b_en, b_dir, b_sat, b_ld;
   logic [2:0] b_ld_val;
   logic [3:0] b_pre;
   logic [2:0] b_cnt;
   logic       b_tc, b_tick;

   int errors = 0;
   int checks = 0;

   m_cnt_gen #(.WIDTH(4), .MODULUS(10), .PRE_W(8)) u_a (
      .w_clk(clk), .w_rst_n(a_rst_n), .w_en(a_en), .w_dir(a_dir), .w_sat(a_sat),
      .w_ld(a_ld), .w_ld_val(a_ld_val), .w_pre(a_pre),
      .w_cnt(a_cnt), .w_tc(a_tc), .w_tick(a_tick)
   );

   m_cnt_gen #(.WIDTH(3), .MODULUS(8), .PRE_W(4)) u_b (
      .w_clk(clk), .w_rst_n(b_rst_n), .w_en(b_en), .w_dir(b_dir), .w_sat(b_sat),
      .w_ld(b_ld), .w_ld_val(b_ld_val), .w_pre(b_pre),
      .w_cnt(b_cnt), .w_tc(b_tc), .w_tick(b_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rst_n = 1'b0; a_en = 1'b1; a_dir = 1'b1; a_sat = 1'b0; a_ld = 1'b0;
      a_ld_val = 4'd0; a_pre = 8'd0;
      b_rst_n = 1'b0; b_en = 1'b0; b_dir = 1'b1; b_sat = 1'b0; b_ld = 1'b0;
      b_ld_val = 3'd0; b_pre = 4'd0;

      // Reset state, with w_en already high and w_pre=0
      #2;
      chk("rst_cnt", 32'(a_cnt), 0);
      chk("rst_tc", 32'(a_tc), 0);
      chk("rst_tick", 32'(a_tick), 0);
      chk("rst_b_cnt", 32'(b_cnt), 0);

      // Up-wrap 0..9,0 with tc only on the wrap
      #10;
      a_rst_n = 1'b1;
      #1;
      chk("tick_after_rel", 32'(a_tick), 1);
      for (int i = 1; i <= 10; i++) begin
         edge1();
         chk($sformatf("upwrap_cnt%0d", i), 32'(a_cnt), 32'(i % 10));
         chk($sformatf("upwrap_tc%0d", i), 32'(a_tc), (i == 10) ? 32'd1 : 32'd0);
      end

      // Prescale by 4 with a 2-cycle enable gap (prescaler currently 0, count 0)
      a_pre = 8'd3;
      #1;
      chk("pre_tick0", 32'(a_tick), 0);
      edge1(); edge1(); edge1();
      chk("pre_tick3", 32'(a_tick), 1);
      chk("pre_cnt3", 32'(a_cnt), 0);
      edge1();
      chk("pre_cnt4", 32'(a_cnt), 1);
      chk("pre_tick4", 32'(a_tick), 0);
      edge1(); edge1();
      a_en = 1'b0;
      #1;
      chk("pre_hold_tick", 32'(a_tick), 0);
      edge1(); edge1();
      chk("pre_hold_cnt", 32'(a_cnt), 1);
      a_en = 1'b1;
      #1;
      chk("pre_resume_tick0", 32'(a_tick), 0);
      edge1();
      chk("pre_resume_tick1", 32'(a_tick), 1);
      chk("pre_resume_cnt", 32'(a_cnt), 1);
      edge1();
      chk("pre_cnt8", 32'(a_cnt), 2);

      // Down-saturate from a load of 2: 2,1,0,0,0 with tc on ticks taken at 0
      a_pre = 8'd0; a_dir = 1'b0; a_sat = 1'b1; a_ld = 1'b1; a_ld_val = 4'd2;
      edge1();
      chk("dsat_cnt_ld", 32'(a_cnt), 2);
      chk("dsat_tc_ld", 32'(a_tc), 0);
      a_ld = 1'b0;
      edge1();
      chk("dsat_cnt1", 32'(a_cnt), 1);
      chk("dsat_tc1", 32'(a_tc), 0);
      edge1();
      chk("dsat_cnt0", 32'(a_cnt), 0);
      chk("dsat_tc0", 32'(a_tc), 0);
      edge1();
      chk("dsat_cnt0b", 32'(a_cnt), 0);
      chk("dsat_tc0b", 32'(a_tc), 1);
      edge1();
      chk("dsat_cnt0c", 32'(a_cnt), 0);
      chk("dsat_tc0c", 32'(a_tc), 1);

      // Load on a terminal-count tick wins and suppresses tc; out-of-range load clamps
      a_ld = 1'b1; a_ld_val = 4'd7;
      #1;
      chk("ld_on_tick", 32'(a_tick), 1);
      edge1();
      chk("ld7_cnt", 32'(a_cnt), 7);
      chk("ld7_tc", 32'(a_tc), 0);
      a_ld_val = 4'd12;
      edge1();
      chk("ld12_cnt", 32'(a_cnt), 9);
      a_ld_val = 4'd10;
      edge1();
      chk("ld10_cnt", 32'(a_cnt), 9);
      a_ld = 1'b0; a_dir = 1'b1; a_sat = 1'b0;
      edge1();
      chk("upwrap9_cnt", 32'(a_cnt), 0);
      chk("upwrap9_tc", 32'(a_tc), 1);

      // Load honoured while disabled; hold otherwise
      a_en = 1'b0; a_ld = 1'b1; a_ld_val = 4'd5;
      edge1();
      chk("ld_dis_cnt", 32'(a_cnt), 5);
      chk("ld_dis_tc", 32'(a_tc), 0);
      a_ld = 1'b0;
      edge1();
      chk("hold_cnt", 32'(a_cnt), 5);

      // Down-wrap 0 -> 9 with tc, then asynchronous reset mid-cycle
      a_en = 1'b1; a_ld = 1'b1; a_ld_val = 4'd0;
      edge1();
      chk("ld0_cnt", 32'(a_cnt), 0);
      a_ld = 1'b0; a_dir = 1'b0;
      edge1();
      chk("dwrap_cnt", 32'(a_cnt), 9);
      chk("dwrap_tc", 32'(a_tc), 1);
      #2;
      a_rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", 32'(a_cnt), 0);
      chk("async_rst_tc", 32'(a_tc), 0);
      chk("async_rst_tick", 32'(a_tick), 0);
      #1;
      a_rst_n = 1'b1;
      edge1();
      chk("rst_resume_cnt", 32'(a_cnt), 9);
      chk("rst_resume_tc", 32'(a_tc), 1);

      // Full-range instance: 6,7,0(tc),1,2 then async reset and resume 0,1,2
      b_rst_n = 1'b1; b_en = 1'b1; b_ld = 1'b1; b_ld_val = 3'd6;
      edge1();
      chk("b_ld6", 32'(b_cnt), 6);
      b_ld = 1'b0;
      edge1();
      chk("b_cnt7", 32'(b_cnt), 7);
      chk("b_tc7", 32'(b_tc), 0);
      edge1();
      chk("b_wrap_cnt", 32'(b_cnt), 0);
      chk("b_wrap_tc", 32'(b_tc), 1);
      edge1();
      chk("b_cnt1", 32'(b_cnt), 1);
      chk("b_tc1", 32'(b_tc), 0);
      edge1();
      chk("b_cnt2", 32'(b_cnt), 2);
      #2;
      b_rst_n = 1'b0;
      #1;
      chk("b_async_rst", 32'(b_cnt), 0);
      #1;
      b_rst_n = 1'b1;
      edge1();
      chk("b_resume1", 32'(b_cnt), 1);
      edge1();
      chk("b_resume2", 32'(b_cnt), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
